// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all eight 3-input combinations into a logic block and captures its truth table
// The captured table is compared against EXPECTED once a sweep completes.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hFE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       match
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] index, index_nxt;
  logic [7:0] count, count_nxt;
  logic       done_nxt;
  logic [7:0] table_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= 3'd0;
      count       <= 8'd0;
      done        <= 1'b0;
      truth_table <= 8'h00;
    end else begin
      state       <= state_nxt;
      index       <= index_nxt;
      count       <= count_nxt;
      done        <= done_nxt;
      truth_table <= table_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    count_nxt = count;
    done_nxt  = done;
    table_nxt = truth_table;
    case (state)
      IDLE: begin
        // abort outranks start, and also drops a completed result
        if (abort) begin
          done_nxt = 1'b0;
        end else if (start) begin
          state_nxt = APPLY;
          index_nxt = 3'd0;
          count_nxt = LOAD;
          done_nxt  = 1'b0;
          table_nxt = 8'h00;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
          index_nxt = 3'd0;
          count_nxt = 8'd0;
        end else if (count == 8'd0) begin
          state_nxt = SAMPLE;
        end else begin
          count_nxt = count - 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
          index_nxt = 3'd0;
          count_nxt = 8'd0;
        end else begin
          // combination 000 lands in bit 7, 111 in bit 0
          table_nxt[~index] = out;
          if (index == 3'd7) begin
            state_nxt = FINISH;
            index_nxt = 3'd0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = APPLY;
            index_nxt = index + 3'd1;
            count_nxt = LOAD;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        if (abort) done_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state == APPLY) || (state == SAMPLE);
  assign {in1, in2, in3} = busy ? index : 3'b000;
  assign match         = done && (truth_table == EXPECTED);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed bench for truth_table_sweeper
// Instance a uses defaults with a NAND3/AND3 model; instance b uses SETTLE_CYCLES=1 with out tied high.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0;
  logic       model_and = 1'b0;
  logic       a1, a2, a3, out_a, busy_a, done_a, match_a;
  logic       b1, b2, b3, busy_b, done_b, match_b;
  logic [7:0] table_a, table_b;
  int         total = 0;
  int         bad = 0;
  int         lat;

  always #5 clk = ~clk;

  assign out_a = model_and ? (a1 & a2 & a3) : ~(a1 & a2 & a3);

  truth_table_sweeper dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .in1(a1), .in2(a2), .in3(a3), .out(out_a),
    .busy(busy_a), .done(done_a), .truth_table(table_a), .match(match_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
    .in1(b1), .in2(b2), .in3(b3), .out(1'b1),
    .busy(busy_b), .done(done_b), .truth_table(table_b), .match(match_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on instance a from IDLE; re-pulses start at cycles 3 and 20,
  // raises abort at abort_at and returns early at stop_at (0 disables each).
  task automatic run_a(input int abort_at, input int stop_at, output int n);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 1;
    check("start_clears_done", done_a, 0);
    check("start_sets_busy", busy_a, 1);
    while (n < 200 && !done_a && n != stop_at) begin
      if (n <= 40) check("walk_a", {a1, a2, a3}, (n - 1) / 5);
      start_a = (n == 3 || n == 20);
      abort_a = (n == abort_at);
      tick();
      n++;
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_in", {a1, a2, a3}, 0);
    check("rst_table", table_a, 8'h00);
    check("rst_match", match_a, 0);
    rst_n = 1'b1;
    tick();

    run_a(0, 0, lat);
    check("nand_latency", lat, 41);
    check("nand_table", table_a, 8'hFE);
    check("nand_match", match_a, 1);
    check("nand_busy", busy_a, 0);
    check("nand_in", {a1, a2, a3}, 0);
    tick();
    check("idle_done_held", done_a, 1);
    check("idle_table_held", table_a, 8'hFE);
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("abort_idle_busy", busy_a, 0);
    check("abort_idle_done", done_a, 0);
    check("abort_idle_match", match_a, 0);
    check("abort_idle_table", table_a, 8'hFE);
    tick();
    check("abort_wins_no_start", busy_a, 0);

    model_and = 1'b1;
    run_a(0, 0, lat);
    check("and_latency", lat, 41);
    check("and_table", table_a, 8'h01);
    check("and_match", match_a, 0);
    check("and_done", done_a, 1);
    tick();
    model_and = 1'b0;

    run_a(12, 13, lat);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_in", {a1, a2, a3}, 0);
    check("abort_table", table_a, 8'hC0);
    check("abort_match", match_a, 0);
    tick();
    check("abort_stays_idle", busy_a, 0);

    run_a(0, 27, lat);
    check("pre_rst_in", {a1, a2, a3}, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_a, 0);
    check("async_rst_in", {a1, a2, a3}, 0);
    check("async_rst_table", table_a, 8'h00);
    check("async_rst_done", done_a, 0);
    check("async_rst_match", match_a, 0);
    #1;
    rst_n = 1'b1;
    tick();
    run_a(0, 0, lat);
    check("post_rst_latency", lat, 41);
    check("post_rst_table", table_a, 8'hFE);
    check("post_rst_match", match_a, 1);

    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 1;
    while (lat < 100 && !done_b) begin
      if (lat <= 16) check("walk_b", {b1, b2, b3}, (lat - 1) / 2);
      tick();
      lat++;
    end
    check("s1_latency", lat, 17);
    check("s1_table", table_b, 8'hFF);
    check("s1_match", match_b, 0);
    check("s1_busy", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
